// File: rtl/model_pu_scheduler_if.sv
// Control bundle between the NTM host controller, model_pu_scheduler and the
// array of processing units.
//   START, SIZE_IN, ENABLE_IN   : host request, step count and unit enable mask
//   READY, BUSY, ITERATION_OUT  : run-complete pulse, run-in-progress flag and
//                                 completed-step count
//   PU_START, PU_READY          : per-unit START pulses and per-unit READY
// master : the side driving requests and unit responses (host plus unit array)
// slave  : the scheduler itself
interface model_pu_scheduler_if #(
  parameter int CONTROL_SIZE = 64,
  parameter int PU_NUMBER    = 4
);
  logic                    START;
  logic                    READY;
  logic                    BUSY;
  logic [CONTROL_SIZE-1:0] SIZE_IN;
  logic [PU_NUMBER-1:0]    ENABLE_IN;
  logic [CONTROL_SIZE-1:0] ITERATION_OUT;
  logic [PU_NUMBER-1:0]    PU_START;
  logic [PU_NUMBER-1:0]    PU_READY;

  modport master (
    output START, SIZE_IN, ENABLE_IN, PU_READY,
    input  READY, BUSY, ITERATION_OUT, PU_START
  );

  modport slave (
    input  START, SIZE_IN, ENABLE_IN, PU_READY,
    output READY, BUSY, ITERATION_OUT, PU_START
  );
endinterface

// File: rtl/model_pu_scheduler.sv
// Host-side sequencer for the NTM processing units. A host START launches a
// run of SIZE_IN steps; every step broadcasts a one-cycle PU_START to the
// enabled units and waits until each of them has answered READY once. A
// one-cycle READY goes back to the host after the last step.
//   CLK, RST : clock and asynchronous active-high reset
//   bus      : scheduler side of model_pu_scheduler_if (see that file)
module model_pu_scheduler #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int PU_NUMBER    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  model_pu_scheduler_if.slave   bus
);

  localparam logic [0:0] STARTER_STATE = 1'b0;
  localparam logic [0:0] WAIT_STATE    = 1'b1;

  // DATA_SIZE has no datapath here; it only takes part in the sanity check.
  generate
    if (PU_NUMBER < 1 || PU_NUMBER > 64 || DATA_SIZE < 1 || CONTROL_SIZE < 1) begin : g_bad_param
      $error("model_pu_scheduler: illegal parameter set");
    end
  endgenerate

  logic [0:0]              state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_q, size_d;
  logic [CONTROL_SIZE-1:0] iter_q, iter_d;
  logic [PU_NUMBER-1:0]    enable_q, enable_d;
  logic [PU_NUMBER-1:0]    mask_q, mask_d;
  logic [PU_NUMBER-1:0]    pu_start_q, pu_start_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  logic [PU_NUMBER-1:0]    merged;
  logic [CONTROL_SIZE-1:0] iter_inc;

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    iter_d     = iter_q;
    enable_d   = enable_q;
    mask_d     = mask_q;
    pu_start_d = '0;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    merged     = mask_q | (bus.PU_READY & enable_q);
    iter_inc   = iter_q + CONTROL_SIZE'(1);

    case (state_q)
      STARTER_STATE: begin
        if (bus.START) begin
          size_d   = bus.SIZE_IN;
          enable_d = bus.ENABLE_IN;
          iter_d   = '0;
          mask_d   = '0;
          if (bus.SIZE_IN == '0 || bus.ENABLE_IN == '0) begin
            // Nothing to run: answer immediately without touching the units.
            ready_d = 1'b1;
          end else begin
            pu_start_d = bus.ENABLE_IN;
            busy_d     = 1'b1;
            state_d    = WAIT_STATE;
          end
        end
      end
      default: begin
        // enable_q is never zero here, so a non-zero pu_start_q marks the
        // START cycle. Readies are ignored then so a unit holding READY
        // from the previous step cannot complete the new step early.
        if (pu_start_q == '0) begin
          if (merged == enable_q) begin
            iter_d = iter_inc;
            mask_d = '0;
            if (iter_inc == size_q) begin
              ready_d = 1'b1;
              busy_d  = 1'b0;
              state_d = STARTER_STATE;
            end else begin
              pu_start_d = enable_q;
            end
          end else begin
            mask_d = merged;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= STARTER_STATE;
      size_q     <= '0;
      iter_q     <= '0;
      enable_q   <= '0;
      mask_q     <= '0;
      pu_start_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      iter_q     <= iter_d;
      enable_q   <= enable_d;
      mask_q     <= mask_d;
      pu_start_q <= pu_start_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.READY         = ready_q;
  assign bus.BUSY          = busy_q;
  assign bus.ITERATION_OUT = iter_q;
  assign bus.PU_START      = pu_start_q;

endmodule

// File: tb/tb_model_pu_scheduler.sv
module tb_model_pu_scheduler;

  logic CLK;
  logic RST;
  int   tests_run;
  int   tests_failed;

  model_pu_scheduler_if #(.CONTROL_SIZE(64), .PU_NUMBER(4)) bus ();

  model_pu_scheduler #(.DATA_SIZE(64), .CONTROL_SIZE(64), .PU_NUMBER(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Per-cycle log of a run; index 1 is the cycle after the START edge.
  logic [3:0]  lps [0:39];
  logic        lr  [0:39];
  logic        lb  [0:39];
  logic [63:0] li  [0:39];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input logic [63:0] size, input logic [3:0] en);
    bus.START     = 1'b1;
    bus.SIZE_IN   = size;
    bus.ENABLE_IN = en;
    tick();
    bus.START = 1'b0;
  endtask

  // Plays the unit array: unit i pulses READY d[i] cycles after its PU_START,
  // units in 'stuck' hold READY high. Logs the outputs of ncyc cycles.
  task automatic record(input int ncyc, input logic [3:0] stuck,
                        input int d0, input int d1, input int d2, input int d3);
    int last [4];
    int d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) last[i] = -100;
    for (int c = 1; c <= ncyc; c++) begin
      lps[c] = bus.PU_START;
      lr[c]  = bus.READY;
      lb[c]  = bus.BUSY;
      li[c]  = bus.ITERATION_OUT;
      for (int i = 0; i < 4; i++) begin
        if (bus.PU_START[i]) last[i] = c;
        bus.PU_READY[i] = stuck[i] | (c == last[i] + d[i]);
      end
      tick();
    end
    bus.PU_READY = '0;
  endtask

  task automatic test_reset();
    tests_run++; if (bus.READY !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %0b want 0", bus.READY); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", bus.BUSY); end
    tests_run++; if (bus.PU_START !== 4'h0) begin tests_failed++; $display("FAIL reset_pu_start got %0h want 0", bus.PU_START); end
    tests_run++; if (bus.ITERATION_OUT !== 64'd0) begin tests_failed++; $display("FAIL reset_iter got %0d want 0", bus.ITERATION_OUT); end
    // Reset during the first PU_START cycle of a run.
    launch(64'd2, 4'hF);
    tests_run++; if (bus.PU_START !== 4'hF) begin tests_failed++; $display("FAIL midrun_pu_start got %0h want f", bus.PU_START); end
    tests_run++; if (bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL midrun_busy got %0b want 1", bus.BUSY); end
    #2 RST = 1'b1;
    #1;
    tests_run++; if (bus.PU_START !== 4'h0) begin tests_failed++; $display("FAIL async_rst_pu_start got %0h want 0", bus.PU_START); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL async_rst_busy got %0b want 0", bus.BUSY); end
    #1 RST = 1'b0;
    tick();
    launch(64'd1, 4'hF);
    record(4, 4'h0, 1, 1, 1, 1);
    tests_run++; if (lr[3] !== 1'b1) begin tests_failed++; $display("FAIL post_rst_ready got %0b want 1", lr[3]); end
    tests_run++; if (li[4] !== 64'd1) begin tests_failed++; $display("FAIL post_rst_iter got %0d want 1", li[4]); end
    tests_run++; if (lr[1] !== 1'b0) begin tests_failed++; $display("FAIL post_rst_no_early_ready got %0b want 0", lr[1]); end
  endtask

  task automatic test_basic();
    int nstart;
    int nready;
    launch(64'd3, 4'hF);
    record(10, 4'h0, 1, 1, 1, 1);
    nstart = 0; nready = 0;
    for (int c = 1; c <= 10; c++) begin
      if (lps[c] != 4'h0) nstart++;
      if (lr[c]) nready++;
    end
    tests_run++; if (nstart !== 3) begin tests_failed++; $display("FAIL basic_start_count got %0d want 3", nstart); end
    tests_run++; if ({lps[1], lps[3], lps[5]} !== 12'hFFF) begin tests_failed++; $display("FAIL basic_start_cycles got %0h want fff", {lps[1], lps[3], lps[5]}); end
    tests_run++; if (lr[7] !== 1'b1 || nready !== 1) begin tests_failed++; $display("FAIL basic_ready got lr7=%0b n=%0d want 1/1", lr[7], nready); end
    tests_run++; if (li[8] !== 64'd3) begin tests_failed++; $display("FAIL basic_iter got %0d want 3", li[8]); end
    tests_run++; if ({lb[6], lb[7]} !== 2'b10) begin tests_failed++; $display("FAIL basic_busy got %0b want 10", {lb[6], lb[7]}); end
    tests_run++; if (li[4] !== 64'd1) begin tests_failed++; $display("FAIL basic_iter_mid got %0d want 1", li[4]); end
  endtask

  task automatic test_staggered();
    launch(64'd1, 4'hF);
    record(9, 4'h0, 1, 3, 5, 2);
    tests_run++; if (lr[6] !== 1'b0) begin tests_failed++; $display("FAIL stagger_early got %0b want 0", lr[6]); end
    tests_run++; if (lr[7] !== 1'b1) begin tests_failed++; $display("FAIL stagger_ready got %0b want 1", lr[7]); end
    tests_run++; if (lb[6] !== 1'b1) begin tests_failed++; $display("FAIL stagger_busy got %0b want 1", lb[6]); end
    tests_run++; if (li[8] !== 64'd1) begin tests_failed++; $display("FAIL stagger_iter got %0d want 1", li[8]); end
  endtask

  task automatic test_partial_enable();
    logic bad;
    launch(64'd2, 4'b0101);
    record(8, 4'b0010, 1, 1, 1, 1);
    bad = 1'b0;
    for (int c = 1; c <= 8; c++) if (lps[c] != 4'h0 && lps[c] != 4'b0101) bad = 1'b1;
    tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL partial_pu_start_mask got bad=%0b want 0", bad); end
    tests_run++; if ({lps[1], lps[3]} !== 8'h55) begin tests_failed++; $display("FAIL partial_start_cycles got %0h want 55", {lps[1], lps[3]}); end
    tests_run++; if (lr[5] !== 1'b1) begin tests_failed++; $display("FAIL partial_ready got %0b want 1", lr[5]); end
    tests_run++; if (li[6] !== 64'd2) begin tests_failed++; $display("FAIL partial_iter got %0d want 2", li[6]); end
  endtask

  task automatic test_degenerate();
    launch(64'd0, 4'hF);
    tests_run++; if (bus.READY !== 1'b1) begin tests_failed++; $display("FAIL zero_size_ready got %0b want 1", bus.READY); end
    tests_run++; if (bus.PU_START !== 4'h0 || bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL zero_size_idle got ps=%0h busy=%0b want 0/0", bus.PU_START, bus.BUSY); end
    tests_run++; if (bus.ITERATION_OUT !== 64'd0) begin tests_failed++; $display("FAIL zero_size_iter_clear got %0d want 0", bus.ITERATION_OUT); end
    tick();
    tests_run++; if (bus.READY !== 1'b0) begin tests_failed++; $display("FAIL zero_size_pulse_width got %0b want 0", bus.READY); end
    launch(64'd5, 4'h0);
    tests_run++; if (bus.READY !== 1'b1 || bus.PU_START !== 4'h0) begin tests_failed++; $display("FAIL zero_en got rdy=%0b ps=%0h want 1/0", bus.READY, bus.PU_START); end
    tests_run++; if (bus.ITERATION_OUT !== 64'd0 || bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL zero_en_state got it=%0d busy=%0b want 0/0", bus.ITERATION_OUT, bus.BUSY); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.START     = 1'b1;
    bus.SIZE_IN   = 64'd2;
    bus.ENABLE_IN = 4'hF;
    tick();
    // START stays high; the new size is only taken when the next run starts.
    bus.SIZE_IN = 64'd7;
    record(22, 4'hF, 99, 99, 99, 99);
    tests_run++; if ({lps[1], lps[2], lps[3], lps[4]} !== 16'hF0F0) begin tests_failed++; $display("FAIL b2b_step_spacing got %0h want f0f0", {lps[1], lps[2], lps[3], lps[4]}); end
    tests_run++; if (lr[5] !== 1'b1 || li[5] !== 64'd2) begin tests_failed++; $display("FAIL b2b_first_done got rdy=%0b it=%0d want 1/2", lr[5], li[5]); end
    tests_run++; if (lps[6] !== 4'hF || lb[6] !== 1'b1 || li[6] !== 64'd0) begin tests_failed++; $display("FAIL b2b_restart got ps=%0h busy=%0b it=%0d want f/1/0", lps[6], lb[6], li[6]); end
    tests_run++; if (lr[19] !== 1'b0 || lr[20] !== 1'b1 || li[20] !== 64'd7) begin tests_failed++; $display("FAIL b2b_second_done got r19=%0b r20=%0b it=%0d want 0/1/7", lr[19], lr[20], li[20]); end
    tests_run++; if (lps[21] !== 4'hF) begin tests_failed++; $display("FAIL b2b_third_start got %0h want f", lps[21]); end
    bus.START = 1'b0;
    #1 RST = 1'b1;
    #1 RST = 1'b0;
    tick();
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    RST           = 1'b1;
    bus.START     = 1'b0;
    bus.SIZE_IN   = '0;
    bus.ENABLE_IN = '0;
    bus.PU_READY  = '0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_staggered();
    test_partial_enable();
    test_degenerate();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/model_pu_scheduler.md
# model_pu_scheduler

Host-side sequencer for the NTM processing units: it is the initiator end of the START/READY control handshake that every processing unit implements as responder. On a host request it runs SIZE_IN time steps. Each step broadcasts a one-cycle PU_START pulse to the enabled processing units, then waits until every enabled unit has answered with READY. After the last step it returns a one-cycle READY to the host. It sits between the NTM top-level controller and the array of model_pu instances.

## Interface
- DATA_SIZE, 64, datapath width; carried for codebase uniformity, no data path in this block
- CONTROL_SIZE, 64, width of step count and step index
- PU_NUMBER, 4, number of processing units driven (1..64)

- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  reset, asynchronous, active-high
- START  input  1  host request, sampled only in STARTER_STATE
- READY  output  1  registered one-cycle pulse, run complete
- BUSY  output  1  registered, high while a run is in progress
- SIZE_IN  input  CONTROL_SIZE  number of time steps, latched on accepted START
- ENABLE_IN  input  PU_NUMBER  per-unit enable mask, latched on accepted START
- ITERATION_OUT  output  CONTROL_SIZE  completed-step count of the current or last run
- PU_START  output  PU_NUMBER  registered per-unit START pulses
- PU_READY  input  PU_NUMBER  per-unit READY, either level or pulse

## Operation
- Reset values:
  - READY=0, BUSY=0, PU_START=0, ITERATION_OUT=0.
  - Internal size, enable and collected-ready registers are 0.
  - State is STARTER_STATE.
- STARTER_STATE (START=1, run accepted):
  - Latch SIZE_IN and ENABLE_IN; clear ITERATION_OUT and the collected-ready mask.
  - If the latched size is 0 or ENABLE_IN is 0: READY=1 next cycle, BUSY stays 0, no PU_START is issued, remain in STARTER_STATE.
  - Otherwise: PU_START=ENABLE_IN and BUSY=1 next cycle; go to WAIT_STATE.
- START=0 in STARTER_STATE: nothing changes. START is ignored in every other state.
- WAIT_STATE, PU_START high:
  - This is a single cycle; PU_READY is ignored in that cycle.
  - PU_START returns to 0 on the next edge.
- WAIT_STATE, PU_START low:
  - The collected mask becomes mask | (PU_READY & enable). Ready bits from disabled units are discarded.
  - The step completes in the cycle where (mask | (PU_READY & enable)) == enable. On that edge: ITERATION_OUT increments and the mask clears.
  - If the new ITERATION_OUT == size: READY=1 and BUSY=0 next cycle; return to STARTER_STATE.
  - Otherwise: PU_START=enable next cycle (next step); stay in WAIT_STATE.
- A unit's ready seen once is remembered (sticky) until the step completes. A unit holding READY high across steps does not complete the next step early, because READY is ignored during the PU_START cycle and the mask is cleared.
- Counter arithmetic: ITERATION_OUT is unsigned CONTROL_SIZE bits, compared for equality with the latched size. Size = 2^CONTROL_SIZE-1 is legal; there is no wrap within a run.
- After completion ITERATION_OUT holds its value until the next accepted START.
- RST mid-run: all outputs and state return to reset values immediately (asynchronously). Any PU_START pulse is truncated and no READY is produced.

## Timing
- START sampled at edge k → PU_START high during cycle k+1 (first step).
- PU_READY is evaluated from cycle k+2. If all enabled units assert in cycle j: the next PU_START is high in cycle j+1, or READY is high in cycle j+1 on the last step.
- Minimum latency, one step with single-cycle units: START edge k → READY high in cycle k+3.
- Per-step cycle cost: 1 (PU_START) + PU response time.
- Zero-size or zero-enable run: READY high in cycle k+1.
- READY is always exactly one cycle wide. A new START may be sampled in the same cycle READY is high.
- BUSY rises with the first PU_START and falls with READY.

## Test plan
- Reset: assert RST mid-run during WAIT_STATE → READY=0, BUSY=0, PU_START=0, ITERATION_OUT=0 immediately; a subsequent START runs normally.
- Basic run: PU_NUMBER=4, ENABLE_IN=4'hF, SIZE_IN=3, every unit returns READY one cycle after PU_START → three PU_START=4'hF pulses 2 cycles apart; READY in cycle k+7; ITERATION_OUT=3.
- Staggered ready: units answer with single-cycle pulses 1, 3, 5, 2 cycles after PU_START, SIZE_IN=1 → step completes only after the 5-cycle unit answers; READY 1 cycle later.
- Partial enable: ENABLE_IN=4'b0101, PU_READY[1] stuck high, SIZE_IN=2 → PU_START only ever 4'b0101; bit 1 has no effect on completion; ITERATION_OUT=2.
- Degenerate runs: SIZE_IN=0 → READY in cycle k+1, PU_START never asserted. ENABLE_IN=0, SIZE_IN=5 → same response, ITERATION_OUT=0.
- Protocol robustness: START held high through a run, and all PU_READY held high continuously, SIZE_IN=2 → each step still takes 2 cycles; START during BUSY is ignored; a new run starts in the READY cycle.
